// File: rtl/mem_access_stage.sv
// Memory access stage: EX/MEM payload in, req/ack data-memory bus,
// registered MEM/WB payload out, sticky fault on illegal access or timeout.
module mem_access_stage #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  input  logic             FLUSH,
  input  logic [WIDTH-1:0] WRITE_BACK,
  input  logic [WIDTH-1:0] MEMORY,
  input  logic [WIDTH-1:0] REGISTER_VAL1,
  input  logic [WIDTH-1:0] OP1_ADDRESS,
  input  logic [WIDTH-1:0] ALU_RESULT_UPPER,
  input  logic [WIDTH-1:0] ALU_RESULT_LOWER,
  output logic             STALL,
  output logic             DMEM_REQ,
  output logic             DMEM_WE,
  output logic [1:0]       DMEM_BE,
  output logic [WIDTH-1:0] DMEM_ADDR,
  output logic [WIDTH-1:0] DMEM_WDATA,
  input  logic             DMEM_ACK,
  input  logic [WIDTH-1:0] DMEM_RDATA,
  output logic             VALID_OUT,
  output logic [WIDTH-1:0] WB_CTRL_OUT,
  output logic [WIDTH-1:0] RESULT_OUT,
  output logic [WIDTH-1:0] RESULT_UPPER_OUT,
  output logic [WIDTH-1:0] DEST_OUT,
  output logic             MEM_FAULT
);

  typedef enum logic {IDLE, REQ} state_t;

  // reg-write and upper-write enables, cleared on a faulted instruction
  localparam logic [WIDTH-1:0] WB_KILL = WIDTH'(5);

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic            flush_q;

  logic             memop;
  logic             illegal;
  logic             legal;
  logic             take;
  logic             to_hit;
  logic             drop;
  logic [1:0]       be;
  logic [WIDTH-1:0] st_data;
  logic [WIDTH-1:0] rd_val;
  logic             unused_mem;

  assign memop   = MEMORY[0] | MEMORY[1];
  assign illegal = memop & ((MEMORY[0] & MEMORY[1]) |
                            (~MEMORY[2] & ALU_RESULT_LOWER[0]));
  assign legal   = memop & ~illegal;
  assign take    = (state == IDLE) & IN_VALID & ~FLUSH;
  assign STALL   = (state == REQ) | (take & legal);
  assign to_hit  = (to_cnt == TO_W'(TIMEOUT - 1));
  assign drop    = flush_q | FLUSH;

  assign unused_mem = ^MEMORY[WIDTH-1:3];

  assign be = MEMORY[2] ? (ALU_RESULT_LOWER[0] ? 2'b10 : 2'b01)
                        : 2'b11;

  assign st_data = MEMORY[2] ? {(WIDTH/8){REGISTER_VAL1[7:0]}}
                             : REGISTER_VAL1;

  // byte reads pick the lane that was enabled on the bus
  always_comb begin
    rd_val = DMEM_RDATA;
    if (DMEM_BE != 2'b11) begin
      rd_val = {{(WIDTH-8){1'b0}},
                DMEM_BE[1] ? DMEM_RDATA[15:8] : DMEM_RDATA[7:0]};
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state            <= IDLE;
      to_cnt           <= '0;
      flush_q          <= 1'b0;
      DMEM_REQ         <= 1'b0;
      DMEM_WE          <= 1'b0;
      DMEM_BE          <= 2'b00;
      DMEM_ADDR        <= '0;
      DMEM_WDATA       <= '0;
      VALID_OUT        <= 1'b0;
      WB_CTRL_OUT      <= '0;
      RESULT_OUT       <= '0;
      RESULT_UPPER_OUT <= '0;
      DEST_OUT         <= '0;
      MEM_FAULT        <= 1'b0;
    end else begin
      VALID_OUT <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            WB_CTRL_OUT      <= WRITE_BACK;
            RESULT_OUT       <= ALU_RESULT_LOWER;
            RESULT_UPPER_OUT <= ALU_RESULT_UPPER;
            DEST_OUT         <= OP1_ADDRESS;
            unique case (1'b1)
              illegal: begin
                MEM_FAULT   <= 1'b1;
                VALID_OUT   <= 1'b1;
                WB_CTRL_OUT <= WRITE_BACK & ~WB_KILL;
              end
              legal: begin
                state      <= REQ;
                to_cnt     <= '0;
                flush_q    <= 1'b0;
                DMEM_REQ   <= 1'b1;
                DMEM_WE    <= MEMORY[1];
                DMEM_BE    <= be;
                DMEM_ADDR  <= ALU_RESULT_LOWER >> 1;
                DMEM_WDATA <= st_data;
              end
              default: VALID_OUT <= 1'b1;
            endcase
          end
        end
        REQ: begin
          if (FLUSH) flush_q <= 1'b1;
          if (DMEM_ACK) begin
            state     <= IDLE;
            DMEM_REQ  <= 1'b0;
            flush_q   <= 1'b0;
            VALID_OUT <= ~drop;
            if (!DMEM_WE) RESULT_OUT <= rd_val;
          end else if (to_hit) begin
            state       <= IDLE;
            DMEM_REQ    <= 1'b0;
            flush_q     <= 1'b0;
            MEM_FAULT   <= 1'b1;
            VALID_OUT   <= ~drop;
            WB_CTRL_OUT <= WB_CTRL_OUT & ~WB_KILL;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage against a transaction-level
// model of expected bus activity and MEM/WB results.
module tb_mem_access_stage;

  localparam int TMO = 15;

  logic        CLK, RST, IN_VALID, FLUSH;
  logic [15:0] WRITE_BACK, MEMORY, REGISTER_VAL1, OP1_ADDRESS;
  logic [15:0] ALU_RESULT_UPPER, ALU_RESULT_LOWER;
  logic        STALL, DMEM_REQ, DMEM_WE, DMEM_ACK;
  logic [1:0]  DMEM_BE;
  logic [15:0] DMEM_ADDR, DMEM_WDATA, DMEM_RDATA;
  logic        VALID_OUT, MEM_FAULT;
  logic [15:0] WB_CTRL_OUT, RESULT_OUT, RESULT_UPPER_OUT, DEST_OUT;

  mem_access_stage #(.WIDTH(16), .TIMEOUT(TMO), .TO_W(4)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .FLUSH(FLUSH),
    .WRITE_BACK(WRITE_BACK), .MEMORY(MEMORY),
    .REGISTER_VAL1(REGISTER_VAL1), .OP1_ADDRESS(OP1_ADDRESS),
    .ALU_RESULT_UPPER(ALU_RESULT_UPPER),
    .ALU_RESULT_LOWER(ALU_RESULT_LOWER),
    .STALL(STALL), .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE),
    .DMEM_BE(DMEM_BE), .DMEM_ADDR(DMEM_ADDR),
    .DMEM_WDATA(DMEM_WDATA), .DMEM_ACK(DMEM_ACK),
    .DMEM_RDATA(DMEM_RDATA), .VALID_OUT(VALID_OUT),
    .WB_CTRL_OUT(WB_CTRL_OUT), .RESULT_OUT(RESULT_OUT),
    .RESULT_UPPER_OUT(RESULT_UPPER_OUT), .DEST_OUT(DEST_OUT),
    .MEM_FAULT(MEM_FAULT)
  );

  typedef struct {
    int          cyc;
    logic [15:0] wb, res, up, dest;
    bit          chk_res;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   run = 0;
  int   last_run = 0;

  logic        exp_stall = 0, exp_req = 0, exp_we = 0, exp_fault = 0;
  logic [1:0]  exp_be = 0;
  logic [15:0] exp_addr = 0, exp_wdata = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, expv, cyc);
    end
  endtask

  // per-cycle compare against the model
  always @(negedge CLK) begin
    bit ev;
    chk("stall", 32'(STALL), 32'(exp_stall));
    chk("req", 32'(DMEM_REQ), 32'(exp_req));
    chk("fault", 32'(MEM_FAULT), 32'(exp_fault));
    if (exp_req) begin
      chk("we", 32'(DMEM_WE), 32'(exp_we));
      chk("be", 32'(DMEM_BE), 32'(exp_be));
      chk("addr", 32'(DMEM_ADDR), 32'(exp_addr));
      chk("wdata", 32'(DMEM_WDATA), 32'(exp_wdata));
    end
    ev = (q.size() > 0) && (q[0].cyc == cyc);
    chk("valid", 32'(VALID_OUT), 32'(ev));
    if (ev) begin
      if (VALID_OUT) begin
        chk("wb", 32'(WB_CTRL_OUT), 32'(q[0].wb));
        chk("upper", 32'(RESULT_UPPER_OUT), 32'(q[0].up));
        chk("dest", 32'(DEST_OUT), 32'(q[0].dest));
        if (q[0].chk_res)
          chk("result", 32'(RESULT_OUT), 32'(q[0].res));
      end
      void'(q.pop_front());
    end
    if (DMEM_REQ) run++;
    else if (run != 0) begin
      last_run = run;
      run = 0;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    IN_VALID = 0; FLUSH = 0; WRITE_BACK = 0; MEMORY = 0;
    REGISTER_VAL1 = 0; OP1_ADDRESS = 0; ALU_RESULT_UPPER = 0;
    ALU_RESULT_LOWER = 0; DMEM_ACK = 0; DMEM_RDATA = 0;
  endtask

  task automatic do_reset();
    RST = 0;
    clear_inputs();
    exp_stall = 0; exp_req = 0; exp_fault = 0;
    q.delete();
    step();
    step();
    RST = 1;
  endtask

  task automatic idle();
    IN_VALID = 0;
    FLUSH = 1'($urandom);
    MEMORY = 16'($urandom);
    DMEM_ACK = 1'($urandom);
    exp_stall = 0;
    step();
  endtask

  // fl: 0 none, 1 flush while presented, k+1 flush in k-th REQ cycle
  // d: REQ cycle in which ACK arrives; d > TMO withholds it
  task automatic issue(input logic [15:0] wb, mem, val, dest, up, lo,
                       input logic [15:0] rdata, input int d,
                       input int fl);
    bit   rd, wr, byt, memop, illegal;
    int   len;
    exp_t e;
    rd = mem[0]; wr = mem[1]; byt = mem[2];
    memop = rd || wr;
    illegal = (rd && wr) || (memop && !byt && lo[0]);
    IN_VALID = 1; FLUSH = (fl == 1);
    WRITE_BACK = wb; MEMORY = mem; REGISTER_VAL1 = val;
    OP1_ADDRESS = dest; ALU_RESULT_UPPER = up;
    ALU_RESULT_LOWER = lo;
    DMEM_ACK = 1'($urandom); DMEM_RDATA = 16'($urandom);
    exp_req = 0;
    exp_stall = memop && !illegal && (fl != 1);
    if (fl == 1) begin
      step();
      return;
    end
    e.wb = wb; e.res = lo; e.up = up; e.dest = dest; e.chk_res = 1;
    if (!exp_stall) begin
      if (illegal) e.wb = wb & ~16'h0005;
      e.cyc = cyc + 1;
      q.push_back(e);
      step();
      if (illegal) exp_fault = 1;
      return;
    end
    len = (d <= TMO) ? d : TMO;
    if (rd)
      e.res = !byt ? rdata :
              (lo[0] ? {8'h00, rdata[15:8]} : {8'h00, rdata[7:0]});
    if (d > TMO) begin
      e.wb = wb & ~16'h0005;
      e.chk_res = 0;
    end
    e.cyc = cyc + len + 1;
    if (fl < 2) q.push_back(e);
    step();
    exp_req = 1; exp_we = wr;
    exp_be = byt ? (lo[0] ? 2'b10 : 2'b01) : 2'b11;
    exp_addr = lo >> 1;
    exp_wdata = byt ? {val[7:0], val[7:0]} : val;
    for (int k = 1; k <= len; k++) begin
      IN_VALID = 1'($urandom);
      MEMORY = 16'($urandom);
      ALU_RESULT_LOWER = 16'($urandom);
      WRITE_BACK = 16'($urandom);
      FLUSH = (fl == k + 1);
      DMEM_ACK = (k == d);
      DMEM_RDATA = (k == d) ? rdata : 16'($urandom);
      step();
    end
    exp_req = 0; exp_stall = 0;
    IN_VALID = 0; FLUSH = 0; DMEM_ACK = 0;
    if (d > TMO) exp_fault = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int kind, d, fl, len;
    logic [15:0] mem, lo, wb;
    RST = 0;
    clear_inputs();
    do_reset();
    chk("reset_valid", 32'(VALID_OUT), 32'h0);
    chk("reset_result", 32'(RESULT_OUT), 32'h0);

    issue(16'h0001, 16'h0000, 16'h0, 16'h3, 16'h0, 16'h1234,
          16'h0, 1, 0);
    chk("alu_valid", 32'(VALID_OUT), 32'h1);
    chk("alu_result", 32'(RESULT_OUT), 32'h1234);
    chk("alu_dest", 32'(DEST_OUT), 32'h3);

    issue(16'h0003, 16'h0001, 16'h0, 16'h5, 16'h0, 16'h0010,
          16'hBEEF, 3, 0);
    chk("ldw_result", 32'(RESULT_OUT), 32'hBEEF);
    issue(16'h0003, 16'h0005, 16'h0, 16'h6, 16'h0, 16'h0011,
          16'hA55A, 2, 0);
    chk("ldb_result", 32'(RESULT_OUT), 32'h00A5);
    issue(16'h0000, 16'h0006, 16'h00C3, 16'h7, 16'h0, 16'h0010,
          16'h0, 1, 0);
    chk("stb_result", 32'(RESULT_OUT), 32'h0010);

    issue(16'h0007, 16'h0001, 16'h0, 16'h2, 16'h0, 16'h0003,
          16'h0, 1, 0);
    chk("illegal_fault", 32'(MEM_FAULT), 32'h1);
    chk("illegal_wb", 32'(WB_CTRL_OUT), 32'h0002);

    do_reset();
    chk("fault_cleared", 32'(MEM_FAULT), 32'h0);
    issue(16'h0007, 16'h0001, 16'h0, 16'h2, 16'h0, 16'h0020,
          16'h0, 20, 0);
    chk("to_fault", 32'(MEM_FAULT), 32'h1);
    chk("to_wb", 32'(WB_CTRL_OUT), 32'h0002);
    @(negedge CLK);
    #1;
    chk("to_req_len", 32'(last_run), 32'd15);
    step();

    // reset asserted in the middle of a request
    do_reset();
    IN_VALID = 1; MEMORY = 16'h0001; ALU_RESULT_LOWER = 16'h0020;
    exp_stall = 1;
    step();
    exp_req = 1; exp_we = 0; exp_be = 2'b11; exp_addr = 16'h0010;
    exp_wdata = 16'h0;
    step();
    #2;
    RST = 0;
    IN_VALID = 0;
    MEMORY = 0;
    #1;
    chk("arst_req", 32'(DMEM_REQ), 32'h0);
    chk("arst_stall", 32'(STALL), 32'h0);
    chk("arst_valid", 32'(VALID_OUT), 32'h0);
    exp_req = 0; exp_stall = 0;
    do_reset();
    issue(16'h0003, 16'h0001, 16'h0, 16'h4, 16'h0, 16'h0030,
          16'h1357, 2, 0);
    chk("post_rst_ld", 32'(RESULT_OUT), 32'h1357);

    issue(16'h0003, 16'h0001, 16'h0, 16'h4, 16'h0, 16'h0040,
          16'h2468, 3, 2);
    chk("flush_novalid", 32'(VALID_OUT), 32'h0);
    issue(16'h0003, 16'h0001, 16'h0, 16'h4, 16'h0, 16'h0042,
          16'h1111, 2, 0);
    chk("b2b_ld_valid", 32'(VALID_OUT), 32'h1);
    issue(16'h0001, 16'h0000, 16'h0, 16'h9, 16'h0, 16'h5555,
          16'h0, 1, 0);
    chk("b2b_alu_valid", 32'(VALID_OUT), 32'h1);
    chk("b2b_alu_res", 32'(RESULT_OUT), 32'h5555);

    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 5);
      lo = 16'($urandom);
      wb = 16'($urandom);
      mem = 16'($urandom) & 16'hFFF8;
      case (kind)
        0: mem = 16'($urandom) & 16'hFFFC;
        1: begin mem = mem | 16'h1; lo[0] = 1'b0; end
        2: mem = mem | 16'h5;
        3: begin mem = mem | 16'h2; lo[0] = 1'b0; end
        4: mem = mem | 16'h6;
        default: begin
          if ($urandom_range(0, 1) == 1) mem = 16'($urandom) | 16'h3;
          else begin mem = mem | 16'h1; lo[0] = 1'b1; end
        end
      endcase
      d = $urandom_range(0, 9);
      d = (d < 8) ? $urandom_range(1, 4) : ((d == 8) ? 15 : 17);
      len = (d <= TMO) ? d : TMO;
      fl = $urandom_range(0, 9);
      fl = (fl == 0) ? 1 :
           ((fl == 1) ? 2 + $urandom_range(0, len - 1) : 0);
      issue(wb, mem, 16'($urandom), 16'($urandom), 16'($urandom),
            lo, 16'($urandom), d, fl);
      if ($urandom_range(0, 3) == 0) idle();
    end

    clear_inputs();
    exp_stall = 0;
    step();
    step();
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the 16-bit pipeline. Consumes the EX/MEM buffer outputs and performs the data-memory load/store over a req/ack bus.
- Stalls upstream while an access is outstanding. Registers the MEM/WB payload: write-back control, result, upper result and destination.
- Detects illegal or misaligned accesses and bus timeouts. Sets a sticky fault flag on any of them.

Parameters:
- WIDTH, 16, datapath and control-word width.
- TIMEOUT, 15, max cycles DMEM_REQ stays high waiting for DMEM_ACK before abort; must be ≥1.
- TO_W, 4, timeout counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- IN_VALID  in  1  EX/MEM payload valid this cycle.
- FLUSH  in  1  synchronous squash of the current/pending instruction.
- WRITE_BACK  in  WIDTH  WB control: [0] reg write, [1] select mem data, [2] write upper result.
- MEMORY  in  WIDTH  mem control: [0] read, [1] write, [2] byte access; other bits ignored.
- REGISTER_VAL1  in  WIDTH  store data.
- OP1_ADDRESS  in  WIDTH  destination register address.
- ALU_RESULT_UPPER  in  WIDTH  upper ALU result.
- ALU_RESULT_LOWER  in  WIDTH  lower ALU result; also the memory byte address.
- STALL  out  1  combinational; upstream holds EX/MEM while high.
- DMEM_REQ  out  1  bus request.
- DMEM_WE  out  1  write strobe.
- DMEM_BE  out  2  byte enables, [1] high byte.
- DMEM_ADDR  out  WIDTH  word address (byte address >> 1).
- DMEM_WDATA  out  WIDTH  store data.
- DMEM_ACK  in  1  bus completion.
- DMEM_RDATA  in  WIDTH  read data, valid when DMEM_ACK is high.
- VALID_OUT  out  1  MEM/WB payload valid, one-cycle pulse per instruction.
- WB_CTRL_OUT  out  WIDTH  write-back control.
- RESULT_OUT  out  WIDTH  lower result.
- RESULT_UPPER_OUT  out  WIDTH  upper result.
- DEST_OUT  out  WIDTH  destination address.
- MEM_FAULT  out  1  sticky fault flag.

Behaviour:
- Reset: async, RST low. State goes to IDLE. All outputs and registers clear to 0, including DMEM_REQ; a request in flight is dropped immediately. MEM_FAULT is cleared only by reset.
- FSM states: IDLE, REQ.
- Define memop = MEMORY[0] | MEMORY[1].
- STALL = (state==REQ) | (state==IDLE & IN_VALID & memop & legal).

IDLE, IN_VALID high, no memop:
- At the next edge, latch WB_CTRL_OUT=WRITE_BACK, RESULT_OUT=ALU_RESULT_LOWER, RESULT_UPPER_OUT=ALU_RESULT_UPPER, DEST_OUT=OP1_ADDRESS.
- Pulse VALID_OUT for one cycle. Latency is 1.

IDLE, illegal access:
- An access is illegal when MEMORY[0]&MEMORY[1] are both set, or on a word access (MEMORY[2]=0) with ALU_RESULT_LOWER[0]=1.
- No bus activity and no stall.
- Next edge: set MEM_FAULT. Emit VALID_OUT with WB_CTRL_OUT[0] and WB_CTRL_OUT[2] forced to 0; other fields pass through.

IDLE, legal memop:
- Next edge: go to REQ and latch the payload. Drive DMEM_REQ=1, DMEM_WE=MEMORY[1], DMEM_ADDR=ALU_RESULT_LOWER>>1, DMEM_WDATA=REGISTER_VAL1.
- Byte enables: DMEM_BE=2'b11 for word access. For byte access, 2'b10 if addr[0] else 2'b01.
- Byte store: replicate the low byte of REGISTER_VAL1 in both lanes.
- Clear the timeout counter.

REQ:
- DMEM_REQ and all DMEM_* outputs stay stable until DMEM_ACK is sampled high.
- On the ACK edge: DMEM_REQ drops, state goes to IDLE, VALID_OUT pulses next cycle.
- Read result: RESULT_OUT = DMEM_RDATA for a word read. For a byte read, the selected byte is zero-extended.
- Write result: RESULT_OUT = ALU_RESULT_LOWER (latched value).
- STALL falls in the cycle after ACK is sampled. The upstream payload presented in that cycle is accepted normally.
- An ACK while in IDLE is ignored.

Timeout:
- The counter increments each REQ cycle without ACK.
- When it reaches TIMEOUT: drop REQ, go to IDLE, set MEM_FAULT. Emit VALID_OUT with write enables forced to 0.

FLUSH:
- In IDLE: no capture and no VALID_OUT for that cycle; STALL is forced to 0.
- In REQ: the bus transaction completes normally (no abort). The pending VALID_OUT is suppressed; the flag is latched until completion.

Simultaneous events:
- ACK and timeout terminal count in the same cycle: ACK wins, no fault.
- VALID_OUT is never high on two consecutive cycles for one instruction.

Test Plan:
- ALU op: IN_VALID=1, MEMORY=0, WRITE_BACK=16'h0001, ALU_RESULT_LOWER=16'h1234, OP1_ADDRESS=3 -> 1 cycle later VALID_OUT=1, RESULT_OUT=16'h1234, DEST_OUT=3, STALL=0 throughout.
- Word load: MEMORY=16'h0001, addr 16'h0010, ACK after 3 cycles with RDATA=16'hBEEF -> DMEM_ADDR=16'h0008, BE=2'b11, REQ held 3 cycles, STALL high until ACK, RESULT_OUT=16'hBEEF.
- Byte load high lane: MEMORY=16'h0005, addr 16'h0011, RDATA=16'hA55A -> BE=2'b10, RESULT_OUT=16'h00A5. Byte store of REGISTER_VAL1=16'h00C3 at addr 16'h0010 -> WE=1, BE=2'b01, WDATA=16'hC3C3.
- Faults: word load at addr 16'h0003 -> no REQ, MEM_FAULT=1, VALID_OUT with WB_CTRL_OUT[0]=0. Separately, ACK withheld -> REQ drops after exactly TIMEOUT=15 cycles, MEM_FAULT=1.
- RST low during REQ -> DMEM_REQ, STALL, VALID_OUT go 0 asynchronously. After release, a new load is accepted in IDLE.
- FLUSH asserted during REQ, ACK 2 cycles later -> transaction completes, no VALID_OUT. Back-to-back load then ALU op -> ALU op result follows 1 cycle after load's VALID_OUT.
